// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, {remainder, quotient}
// kept in a single 2*WIDTH shift register, Run/Ready/Done handshake.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic             Ready,
    output logic             Done,
    output logic             Div_by_zero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [RW-1:0]    r;
    logic [WIDTH-1:0] divisor_q;

    logic [RW-1:0]    shifted;
    logic [WIDTH:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder; diff[WIDTH] is the borrow.
    always_comb begin
        shifted = {r[RW-2:0], 1'b0};
        diff    = {1'b0, shifted[RW-1:WIDTH]} - {1'b0, divisor_q};
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            count       <= '0;
            r           <= '0;
            divisor_q   <= '0;
            Ready       <= 1'b1;
            Done        <= 1'b0;
            Div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        divisor_q   <= Divisor_in;
                        count       <= '0;
                        Div_by_zero <= (Divisor_in == '0);
                        Ready       <= 1'b0;
                        if (Divisor_in == '0) begin
                            // Divide by zero short-circuits straight to an all-ones quotient.
                            r     <= {Dividend_in, {WIDTH{1'b1}}};
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            r     <= {{WIDTH{1'b0}}, Dividend_in};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (diff[WIDTH]) begin
                        r <= shifted;
                    end else begin
                        r <= {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
                    end
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Quotient  = r[WIDTH-1:0];
    assign Remainder = r[RW-1:WIDTH];

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against integer / and % with divide-by-zero rules.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         Reset;
    logic         Run;
    logic [W-1:0] Dividend_in;
    logic [W-1:0] Divisor_in;
    logic         Ready;
    logic         Done;
    logic         Div_by_zero;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Run         (Run),
        .Dividend_in (Dividend_in),
        .Divisor_in  (Divisor_in),
        .Ready       (Ready),
        .Done        (Done),
        .Div_by_zero (Div_by_zero),
        .Quotient    (Quotient),
        .Remainder   (Remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Must be entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after Done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise, input string tag);
        int           lat;
        int           exp_lat;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        exp_q   = (b == 0) ? {W{1'b1}} : a / b;
        exp_r   = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 0 : W;

        chk({tag, ":ready_idle"}, 64'(Ready), 64'd1);
        Run         = 1'b1;
        Dividend_in = a;
        Divisor_in  = b;
        @(posedge clk);
        #1;
        Run = 1'b0;
        if (noise) begin
            Dividend_in = $urandom;
            Divisor_in  = $urandom;
        end
        lat = 0;
        @(negedge clk);
        if (b != 0) chk({tag, ":ready_busy"}, 64'(Ready), 64'd0);
        while (!Done && lat < 100) begin
            if (noise) begin
                Run         = 1'($urandom_range(0, 1));
                Dividend_in = $urandom;
                Divisor_in  = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        Run = 1'b0;
        chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ":done"}, 64'(Done), 64'd1);
        chk({tag, ":quot"}, 64'(Quotient), 64'(exp_q));
        chk({tag, ":rem"}, 64'(Remainder), 64'(exp_r));
        chk({tag, ":dbz"}, 64'(Div_by_zero), 64'(b == 0));
        chk({tag, ":ready_done"}, 64'(Ready), 64'd0);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 64'(Done), 64'd0);
        chk({tag, ":ready_after"}, 64'(Ready), 64'd1);
        chk({tag, ":quot_hold"}, 64'(Quotient), 64'(exp_q));
        chk({tag, ":rem_hold"}, 64'(Remainder), 64'(exp_r));
        chk({tag, ":dbz_hold"}, 64'(Div_by_zero), 64'(b == 0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        Reset       = 1'b0;
        Run         = 1'b0;
        Dividend_in = '0;
        Divisor_in  = '0;
        #12;
        chk("rst:ready", 64'(Ready), 64'd1);
        chk("rst:done", 64'(Done), 64'd0);
        chk("rst:dbz", 64'(Div_by_zero), 64'd0);
        chk("rst:quot", 64'(Quotient), 64'd0);
        chk("rst:rem", 64'(Remainder), 64'd0);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);

        do_op(32'd100, 32'd7, 1'b0, "100/7");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max/max");
        do_op(32'd3, 32'd10, 1'b0, "3/10");
        do_op(32'd0, 32'd5, 1'b0, "0/5");
        do_op(32'd5, 32'd0, 1'b0, "5/0");
        do_op(32'd9, 32'd3, 1'b0, "9/3");
        do_op(32'd12345678, 32'd1234, 1'b1, "noise");
        do_op(32'd77, 32'd8, 1'b0, "b2b");

        // Asynchronous reset in the middle of a calculation.
        Run         = 1'b1;
        Dividend_in = 32'hDEAD_BEEF;
        Divisor_in  = 32'd7;
        @(posedge clk);
        #1;
        Run = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("midrst:busy", 64'(Ready), 64'd0);
        Reset = 1'b0;
        #1;
        chk("midrst:ready", 64'(Ready), 64'd1);
        chk("midrst:done", 64'(Done), 64'd0);
        chk("midrst:quot", 64'(Quotient), 64'd0);
        chk("midrst:rem", 64'(Remainder), 64'd0);
        chk("midrst:dbz", 64'(Div_by_zero), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst:no_done", 64'(Done), 64'd0);
        end
        Reset = 1'b1;
        @(negedge clk);
        do_op(32'd1000, 32'd33, 1'b0, "1000/33");

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = $urandom_range(0, 1) ? ra : ra + 32'd1;
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
